// File: rtl/tri_stream_feeder_if.sv
// Triangle stream from the feeder to the rasterizer: three {z,y,x} vertices,
// the triangle index and a valid/ready handshake.
interface tri_stream_feeder_if #(
    parameter int COORD_W = 9,
    parameter int TIDX_W  = 4
);
    logic [3*COORD_W-1:0] vert1;
    logic [3*COORD_W-1:0] vert2;
    logic [3*COORD_W-1:0] vert3;
    logic                 valid_tri;
    logic [TIDX_W-1:0]    tri_idx;
    logic                 tri_ready;

    modport master (output vert1, vert2, vert3, valid_tri, tri_idx, input tri_ready);
    modport slave  (input vert1, vert2, vert3, valid_tri, tri_idx, output tri_ready);
endinterface

// File: rtl/tri_stream_feeder.sv
// Per-frame triangle source: walks a loadable index table and streams vertex triples.
// Optional macro BACKFACE_CULL_EN drops triangles with non-positive signed area.
module tri_stream_feeder #(
    parameter int NUM_VERTICES = 8,
    parameter int NUM_TRIS     = 12,
    parameter int COORD_W      = 9,
    parameter int VIDX_W       = $clog2(NUM_VERTICES),
    // A one-entry table still needs a 1-bit counter.
    parameter int TIDX_W       = (NUM_TRIS > 1) ? $clog2(NUM_TRIS) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  new_frame,
    input  logic                  vtx_we,
    input  logic [VIDX_W-1:0]     vtx_waddr,
    input  logic [3*COORD_W-1:0]  vtx_wdata,
    input  logic                  idx_we,
    input  logic [TIDX_W-1:0]     idx_waddr,
    input  logic [3*VIDX_W-1:0]   idx_wdata,
    tri_stream_feeder_if.master   tri_if,
    output logic                  obj_done,
    output logic                  busy,
    output logic                  overrun,
    output logic [TIDX_W:0]       cull_count
);
    localparam int VW = 3*COORD_W;

    typedef enum logic [2:0] {
        S_IDLE, S_FIDX, S_FV1, S_FV2, S_FV3, S_CHECK, S_PRESENT, S_DONE
    } state_t;

    state_t              r_state, w_next;
    logic [TIDX_W-1:0]   r_cnt;
    logic [VW-1:0]       r_vtx_mem [NUM_VERTICES];
    logic [3*VIDX_W-1:0] r_idx_mem [NUM_TRIS];
    logic [3*VIDX_W-1:0] r_idx_q;
    logic [VW-1:0]       r_vtx_q;
    logic [VW-1:0]       r_vert1, r_vert2, r_vert3;
    logic                r_overrun;
    logic [VIDX_W-1:0]   w_vaddr;
    logic                w_last, w_cull;

    assign w_last = (r_cnt == TIDX_W'(NUM_TRIS-1));

    // Vertex read address follows the fetch sequence: i1 in FV1, i2 in FV2, i3 otherwise.
    always_comb begin
        w_vaddr = r_idx_q[3*VIDX_W-1:2*VIDX_W];
        if (r_state == S_FV1)      w_vaddr = r_idx_q[VIDX_W-1:0];
        else if (r_state == S_FV2) w_vaddr = r_idx_q[2*VIDX_W-1:VIDX_W];
    end

    // Tables are never reset; non-blocking writes give read-old-data on collisions.
    always_ff @(posedge clk_in) begin
        if (vtx_we && ({1'b0, vtx_waddr} < (VIDX_W+1)'(NUM_VERTICES)))
            r_vtx_mem[vtx_waddr] <= vtx_wdata;
        if (idx_we && ({1'b0, idx_waddr} < (TIDX_W+1)'(NUM_TRIS)))
            r_idx_mem[idx_waddr] <= idx_wdata;
        r_idx_q <= r_idx_mem[r_cnt];
        r_vtx_q <= ({1'b0, w_vaddr} < (VIDX_W+1)'(NUM_VERTICES)) ? r_vtx_mem[w_vaddr] : '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (new_frame) w_next = S_FIDX;
            S_FIDX:    w_next = S_FV1;
            S_FV1:     w_next = S_FV2;
            S_FV2:     w_next = S_FV3;
            S_FV3:     w_next = S_CHECK;
            S_CHECK:   if (w_cull) w_next = w_last ? S_DONE : S_FIDX;
                       else        w_next = S_PRESENT;
            S_PRESENT: if (tri_if.tri_ready) w_next = w_last ? S_DONE : S_FIDX;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt     <= '0;
            r_vert1   <= '0;
            r_vert2   <= '0;
            r_vert3   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= new_frame && (r_state != S_IDLE);
            case (r_state)
                S_IDLE:    if (new_frame) r_cnt <= '0;
                S_FV2:     r_vert1 <= r_vtx_q;
                S_FV3:     r_vert2 <= r_vtx_q;
                S_CHECK: begin
                    r_vert3 <= r_vtx_q;
                    if (w_cull && !w_last) r_cnt <= r_cnt + 1'b1;
                end
                S_PRESENT: if (tri_if.tri_ready && !w_last) r_cnt <= r_cnt + 1'b1;
                default:   ;
            endcase
        end
    end

`ifdef BACKFACE_CULL_EN
    localparam int AW = 2*COORD_W + 3;
    logic signed [COORD_W:0] w_dx21, w_dy31, w_dx31, w_dy21;
    logic signed [AW-1:0]    w_area;
    logic [TIDX_W:0]         r_cull;

    // Vertex 3 is still in the read register during CHECK.
    assign w_dx21 = $signed({1'b0, r_vert2[COORD_W-1:0]}) - $signed({1'b0, r_vert1[COORD_W-1:0]});
    assign w_dx31 = $signed({1'b0, r_vtx_q[COORD_W-1:0]}) - $signed({1'b0, r_vert1[COORD_W-1:0]});
    assign w_dy21 = $signed({1'b0, r_vert2[2*COORD_W-1:COORD_W]}) - $signed({1'b0, r_vert1[2*COORD_W-1:COORD_W]});
    assign w_dy31 = $signed({1'b0, r_vtx_q[2*COORD_W-1:COORD_W]}) - $signed({1'b0, r_vert1[2*COORD_W-1:COORD_W]});
    assign w_area = AW'(w_dx21) * AW'(w_dy31) - AW'(w_dx31) * AW'(w_dy21);
    assign w_cull = (r_state == S_CHECK) && (w_area <= 0);

    always_ff @(posedge clk_in) begin
        if (rst_in)                             r_cull <= '0;
        else if (r_state == S_IDLE && new_frame) r_cull <= '0;
        else if (w_cull && (r_cull != '1))      r_cull <= r_cull + 1'b1;
    end
    assign cull_count = r_cull;
`else
    assign w_cull     = 1'b0;
    assign cull_count = '0;
`endif

    assign tri_if.vert1     = r_vert1;
    assign tri_if.vert2     = r_vert2;
    assign tri_if.vert3     = r_vert3;
    assign tri_if.valid_tri = (r_state == S_PRESENT);
    assign tri_if.tri_idx   = r_cnt;
    assign obj_done         = (r_state == S_DONE);
    assign busy             = (r_state != S_IDLE) && (r_state != S_DONE);
    assign overrun          = r_overrun;
endmodule

// File: tb/tb_tri_stream_feeder.sv
// Directed bench for tri_stream_feeder: latency, stall, overrun, reset abort,
// read/write collision and (with BACKFACE_CULL_EN) culling.
module tb_tri_stream_feeder;
    localparam int NV = 6, NT = 3, CW = 9, VW = 3, TW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, new_frame, vtx_we, idx_we;
    logic [VW-1:0]     vtx_waddr;
    logic [3*CW-1:0]   vtx_wdata;
    logic [TW-1:0]     idx_waddr;
    logic [3*VW-1:0]   idx_wdata;
    logic              obj_done, busy, overrun;
    logic [TW:0]       cull_count;

    tri_stream_feeder_if #(.COORD_W(CW), .TIDX_W(TW)) tri_if ();

    tri_stream_feeder #(.NUM_VERTICES(NV), .NUM_TRIS(NT), .COORD_W(CW)) u_dut (
        .clk_in(clk), .rst_in(rst), .new_frame(new_frame),
        .vtx_we(vtx_we), .vtx_waddr(vtx_waddr), .vtx_wdata(vtx_wdata),
        .idx_we(idx_we), .idx_waddr(idx_waddr), .idx_wdata(idx_wdata),
        .tri_if(tri_if), .obj_done(obj_done), .busy(busy),
        .overrun(overrun), .cull_count(cull_count)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [3*CW-1:0] vx(input int x, input int y, input int z);
        return {z[CW-1:0], y[CW-1:0], x[CW-1:0]};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wv(input int a, input logic [3*CW-1:0] d);
        vtx_we = 1'b1; vtx_waddr = a[VW-1:0]; vtx_wdata = d;
        tick();
        vtx_we = 1'b0;
    endtask

    task automatic wt(input int a, input int i1, input int i2, input int i3);
        idx_we = 1'b1; idx_waddr = a[TW-1:0];
        idx_wdata = {i3[VW-1:0], i2[VW-1:0], i1[VW-1:0]};
        tick();
        idx_we = 1'b0;
    endtask

    // Pulse new_frame for one cycle (cycle N); returns during cycle N+1.
    task automatic start();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
    endtask

    task automatic chk_tri(input string tag, input int t,
                           input logic [3*CW-1:0] a, input logic [3*CW-1:0] b,
                           input logic [3*CW-1:0] c);
        chk({tag, ".valid"}, 64'(tri_if.valid_tri), 64'd1);
        chk({tag, ".idx"},   64'(tri_if.tri_idx), 64'(t));
        chk({tag, ".v1"},    64'(tri_if.vert1), 64'(a));
        chk({tag, ".v2"},    64'(tri_if.vert2), 64'(b));
        chk({tag, ".v3"},    64'(tri_if.vert3), 64'(c));
    endtask

    logic [3*CW-1:0] V0, V1, V2, V3, V4, V5, V1N;
    int hs, dn, vcnt;

    initial begin
        V0 = vx(20, 20, 30);  V1 = vx(40, 20, 30);  V2 = vx(20, 40, 30);
        V3 = vx(100, 50, 7);  V4 = vx(150, 60, 8);  V5 = vx(110, 120, 9);
        V1N = vx(60, 25, 31);
        rst = 1'b1; new_frame = 1'b0; vtx_we = 1'b0; idx_we = 1'b0;
        vtx_waddr = '0; vtx_wdata = '0; idx_waddr = '0; idx_wdata = '0;
        tri_if.tri_ready = 1'b0;
        ticks(2);
        chk("rst.valid", 64'(tri_if.valid_tri), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(obj_done), 64'd0);
        chk("rst.overrun", 64'(overrun), 64'd0);
        chk("rst.cull", 64'(cull_count), 64'd0);
        chk("rst.idx", 64'(tri_if.tri_idx), 64'd0);
        chk("rst.v1", 64'(tri_if.vert1), 64'd0);
        rst = 1'b0;
        tick();

        // Load tables; vertex 7 is outside the table and must read back as zero.
        wv(0, V0); wv(1, V1); wv(2, V2); wv(3, V3); wv(4, V4); wv(5, V5);
        wv(7, vx(1, 2, 3));
        wt(0, 0, 1, 2); wt(1, 3, 4, 5); wt(2, 7, 1, 0);

        // Frame A: ready high, overrun mid-frame and during DONE.
        tri_if.tri_ready = 1'b1;
        start();                                   // N+1
        chk("A.busy", 64'(busy), 64'd1);
        chk("A.valid0", 64'(tri_if.valid_tri), 64'd0);
        ticks(2);                                  // N+3
        new_frame = 1'b1;
        tick();                                    // N+4
        new_frame = 1'b0;
        chk("A.overrun", 64'(overrun), 64'd1);
        tick();                                    // N+5
        chk("A.overrun_clr", 64'(overrun), 64'd0);
        chk("A.valid5", 64'(tri_if.valid_tri), 64'd0);
        tick();                                    // N+6
        chk_tri("A.t0", 0, V0, V1, V2);
        ticks(6);                                  // N+12
        chk_tri("A.t1", 1, V3, V4, V5);
        ticks(6);                                  // N+18
        chk_tri("A.t2", 2, '0, V1, V0);
        tick();                                    // N+19
        chk("A.done", 64'(obj_done), 64'd1);
        chk("A.busy_end", 64'(busy), 64'd0);
        chk("A.valid_end", 64'(tri_if.valid_tri), 64'd0);
        chk("A.cull", 64'(cull_count), 64'd0);
        new_frame = 1'b1;
        tick();                                    // N+20
        new_frame = 1'b0;
        chk("A.done_clr", 64'(obj_done), 64'd0);
        chk("A.overrun_done", 64'(overrun), 64'd1);
        tick();
        chk("A.idle_busy", 64'(busy), 64'd0);

        // Frame B: stall on triangle 1 for 20 cycles.
        tri_if.tri_ready = 1'b0;
        start();
        ticks(5);                                  // N+6
        chk_tri("B.t0", 0, V0, V1, V2);
        ticks(2);
        chk_tri("B.t0hold", 0, V0, V1, V2);
        tri_if.tri_ready = 1'b1;
        tick();
        tri_if.tri_ready = 1'b0;
        ticks(5);
        for (int i = 0; i < 20; i++) begin
            chk_tri($sformatf("B.stall%0d", i), 1, V3, V4, V5);
            tick();
        end
        tri_if.tri_ready = 1'b1;
        hs = 1; dn = 0;
        for (int i = 0; i < 30; i++) begin
            if (tri_if.valid_tri && tri_if.tri_ready) hs++;
            if (obj_done) dn++;
            tick();
        end
        chk("B.handshakes", 64'(hs), 64'd3);
        chk("B.done_cnt", 64'(dn), 64'd1);
        chk("B.busy_end", 64'(busy), 64'd0);

        // Frame C: reset while presenting aborts without obj_done.
        tri_if.tri_ready = 1'b0;
        start();
        ticks(5);
        chk("C.valid", 64'(tri_if.valid_tri), 64'd1);
        rst = 1'b1;
        tick();
        chk("C.rst_valid", 64'(tri_if.valid_tri), 64'd0);
        chk("C.rst_busy", 64'(busy), 64'd0);
        chk("C.rst_done", 64'(obj_done), 64'd0);
        chk("C.rst_v1", 64'(tri_if.vert1), 64'd0);
        rst = 1'b0;
        tick();
        chk("C.post_done", 64'(obj_done), 64'd0);
        tri_if.tri_ready = 1'b1;
        start();
        ticks(5);
        chk_tri("C.t0", 0, V0, V1, V2);
        ticks(13);
        chk("C.done", 64'(obj_done), 64'd1);
        tick();

        // Frame D: vertex 1 written in the cycle it is read for vert2.
        start();                                   // N+1
        ticks(2);                                  // N+3 (FV2)
        vtx_we = 1'b1; vtx_waddr = 3'd1; vtx_wdata = V1N;
        tick();
        vtx_we = 1'b0;
        ticks(2);                                  // N+6
        chk_tri("D.old", 0, V0, V1, V2);
        ticks(13);
        chk("D.done", 64'(obj_done), 64'd1);
        tick();
        start();
        ticks(5);
        chk_tri("D.new", 0, V0, V1N, V2);
        ticks(12);
        chk_tri("D.t2new", 2, '0, V1N, V0);
        tick();
        chk("D.done2", 64'(obj_done), 64'd1);
        tick();

`ifdef BACKFACE_CULL_EN
        // Frame E: one front-facing, one back-facing, one degenerate triangle.
        wv(1, V1);
        wt(0, 0, 1, 2); wt(1, 0, 2, 1); wt(2, 0, 0, 1);
        start();
        ticks(5);                                  // N+6
        chk_tri("E.t0", 0, V0, V1, V2);
        tick();
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (tri_if.valid_tri) vcnt++;
            tick();
        end                                        // N+17
        chk("E.culled_valid", 64'(vcnt), 64'd0);
        chk("E.done", 64'(obj_done), 64'd1);
        chk("E.cull", 64'(cull_count), 64'd2);
        tick();
        chk("E.cull_hold", 64'(cull_count), 64'd2);
        start();
        chk("E.cull_clr", 64'(cull_count), 64'd0);
        ticks(20);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
